// File: rtl/uart_receive.sv
// UART 8N1 receiver: samples din at mid-bit and reassembles LSB-first bytes.
// Latency: din_vld/frame_err pulse 4 + HALF_T + 9*(FULL_T+1) clk after the start-bit falling edge.
// Backpressure: none; each result is a one-cycle pulse that the consumer must take when it appears.
module uart_receive #(
  parameter int FULL_T = 867,
  parameter int HALF_T = 433
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  output logic       din_vld,
  output logic [7:0] din_data,
  output logic       frame_err
);

  localparam logic [9:0] FULL_V = FULL_T[9:0];
  localparam logic [9:0] HALF_V = HALF_T[9:0];

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t      state;
  logic        din_m;
  logic        din_s;
  logic        din_s_d;
  logic [9:0]  div_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift;
  logic        fall;

  // Two-flop synchroniser plus one delay stage for falling-edge detection; idles high.
  always_ff @(posedge clk) begin
    if (rst) begin
      din_m   <= 1'b1;
      din_s   <= 1'b1;
      din_s_d <= 1'b1;
    end else begin
      din_m   <= din;
      din_s   <= din_m;
      din_s_d <= din_s;
    end
  end

  // A start bit begins only on a true high-to-low transition, so a held-low break never retriggers.
  assign fall = din_s_d & ~din_s;

  // Receive FSM: mid-start check, eight mid-bit data samples, then the stop-bit verdict.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      div_cnt   <= 10'd0;
      bit_cnt   <= 3'd0;
      shift     <= 8'h00;
      din_vld   <= 1'b0;
      frame_err <= 1'b0;
      din_data  <= 8'h00;
    end else begin
      din_vld   <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          div_cnt <= 10'd0;
          if (fall) begin
            state <= START;
          end
        end

        START: begin
          if (div_cnt == HALF_V) begin
            div_cnt <= 10'd0;
            bit_cnt <= 3'd0;
            // Line back high at mid-start means it was a glitch, not a frame.
            state   <= din_s ? IDLE : DATA;
          end else begin
            div_cnt <= div_cnt + 10'd1;
          end
        end

        DATA: begin
          if (div_cnt == FULL_V) begin
            div_cnt        <= 10'd0;
            shift[bit_cnt] <= din_s;
            if (bit_cnt == 3'd7) begin
              state <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            div_cnt <= div_cnt + 10'd1;
          end
        end

        STOP: begin
          if (div_cnt == FULL_V) begin
            div_cnt <= 10'd0;
            // Leaving at mid-stop keeps half a bit for catching a back-to-back start edge.
            state   <= IDLE;
            if (din_s) begin
              din_data <= shift;
              din_vld  <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            div_cnt <= div_cnt + 10'd1;
          end
        end

        default: begin
          state   <= IDLE;
          div_cnt <= 10'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receive.sv
// Bench for uart_receive with a shortened bit period so whole-byte sweeps stay short.
// Sender model drives framed bytes with optional baud skew; a monitor logs output pulses.
// Expected bytes/latencies come from the frame rules, compared per test phase.
module tb_uart_receive;

  localparam int FULL_T = 15;
  localparam int HALF_T = 7;
  localparam int BIT    = FULL_T + 1;
  localparam int LAT    = 2 + 1 + HALF_T + 1 + 9 * BIT;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       din = 1'b1;
  logic       din_vld;
  logic [7:0] din_data;
  logic       frame_err;

  uart_receive #(.FULL_T(FULL_T), .HALF_T(HALF_T)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_vld   (din_vld),
    .din_data  (din_data),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;
  int both   = 0;

  // expected good bytes / frame errors: value and start-edge cycle
  int exp_d[$];
  int exp_s[$];
  int fe_ed[$];
  int fe_es[$];
  // observed pulses: din_data and cycle
  int got_d[$];
  int got_c[$];
  int fe_gd[$];
  int fe_gc[$];
  logic [7:0] last_good = 8'h00;

  task automatic chk(input string tag, input int got, input int exp, input int tol = 0);
    n_chk++;
    if (got >= exp - tol && got <= exp + tol) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) tol %0d", tag, got, got, exp, exp, tol);
  endtask

  // Output monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (din_vld) begin
      got_d.push_back(int'(din_data));
      got_c.push_back(cyc);
    end
    if (frame_err) begin
      fe_gd.push_back(int'(din_data));
      fe_gc.push_back(cyc);
    end
    if (din_vld && frame_err) both++;
  end

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive nslots of the 10-slot frame; pct scales the bit period (100 = nominal).
  task automatic send(input logic [7:0] d, input int pct, input logic stop_b, input int nslots);
    logic [9:0] bits;
    int t0;
    bits = {stop_b, d, 1'b0};
    t0   = cyc;
    for (int k = 0; k < nslots; k++) begin
      din = bits[k];
      wait_until(t0 + ((k + 1) * BIT * pct + 50) / 100);
    end
    if (nslots == 10) begin
      if (stop_b) begin
        exp_d.push_back(int'(d));
        exp_s.push_back(t0);
        last_good = d;
      end else begin
        fe_ed.push_back(int'(last_good));
        fe_es.push_back(t0);
      end
    end
  endtask

  task automatic check_phase(input string name);
    int n;
    chk({name, "_vld_count"}, got_d.size(), exp_d.size());
    n = (got_d.size() < exp_d.size()) ? got_d.size() : exp_d.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_data%0d", name, i), got_d[i], exp_d[i]);
      chk($sformatf("%s_lat%0d", name, i), got_c[i] - exp_s[i], LAT, 3);
    end
    chk({name, "_ferr_count"}, fe_gd.size(), fe_ed.size());
    n = (fe_gd.size() < fe_ed.size()) ? fe_gd.size() : fe_ed.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_ferr_data%0d", name, i), fe_gd[i], fe_ed[i]);
      chk($sformatf("%s_ferr_lat%0d", name, i), fe_gc[i] - fe_es[i], LAT, 3);
    end
    exp_d.delete(); exp_s.delete(); fe_ed.delete(); fe_es.delete();
    got_d.delete(); got_c.delete(); fe_gd.delete(); fe_gc.delete();
  endtask

  // Watchdog keeps the run bounded even if the sender loop misbehaves.
  initial begin
    wait (cyc >= 95000);
    $display("FAIL watchdog: reached cycle %0d, limit 95000", cyc);
    $display("%0d/%0d checks passed", n_pass, n_chk + 1);
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] d;
    logic       sb;

    // reset state
    wait_cyc(4);
    chk("rst_vld", int'(din_vld), 0);
    chk("rst_ferr", int'(frame_err), 0);
    chk("rst_data", int'(din_data), 0);
    rst = 1'b0;
    wait_cyc(3);

    // 1: single byte
    send(8'h55, 100, 1'b1, 10);
    wait_cyc(2 * BIT);
    check_phase("single");

    // 2: back-to-back, no idle gap
    send(8'hA3, 100, 1'b1, 10);
    send(8'h00, 100, 1'b1, 10);
    send(8'hFF, 100, 1'b1, 10);
    wait_cyc(2 * BIT);
    check_phase("b2b");

    // 3: short glitch, then a real frame
    din = 1'b0;
    wait_cyc(4);
    din = 1'b1;
    wait_cyc(2 * BIT);
    check_phase("glitch");
    send(8'h3C, 100, 1'b1, 10);
    wait_cyc(2 * BIT);
    check_phase("post_glitch");

    // 4: framing error followed by a long break
    send(8'h12, 100, 1'b1, 10);
    send(8'h3C, 100, 1'b0, 10);
    wait_cyc(5000);
    din = 1'b1;
    wait_cyc(2 * BIT);
    check_phase("ferr");
    chk("ferr_data_held", int'(din_data), 8'h12);
    send(8'h7E, 100, 1'b1, 10);
    wait_cyc(2 * BIT);
    check_phase("post_ferr");

    // 5: reset during data bit 4; the sender is reset with it and releases the line
    send(8'hC6, 100, 1'b1, 5);
    din = 1'b0;
    wait_cyc(BIT / 2);
    rst = 1'b1;
    din = 1'b1;
    wait_cyc(1);
    rst = 1'b0;
    chk("midrst_vld", int'(din_vld), 0);
    chk("midrst_ferr", int'(frame_err), 0);
    chk("midrst_data", int'(din_data), 0);
    wait_cyc(12 * BIT);
    check_phase("midrst");
    send(8'h81, 100, 1'b1, 10);
    wait_cyc(2 * BIT);
    check_phase("post_rst");

    // 6: full byte sweep, back-to-back
    for (int i = 0; i < 256; i++) send(8'(i), 100, 1'b1, 10);
    wait_cyc(2 * BIT);
    check_phase("sweep");

    // 7: random bytes, +-2% baud skew, random gaps, occasional bad stop bit
    for (int i = 0; i < 40; i++) begin
      d  = 8'($urandom_range(0, 255));
      sb = ($urandom_range(0, 5) != 0);
      send(d, int'($urandom_range(98, 102)), sb, 10);
      din = 1'b1;
      if (!sb) wait_cyc(BIT);
      wait_cyc(int'($urandom_range(0, BIT)));
    end
    wait_cyc(2 * BIT);
    check_phase("random");

    chk("never_both", both, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_receive.md
Name: uart_receive

Overview:
UART 8N1 receiver: the receive-side counterpart of the team's UART transmitter.
- Samples the asynchronous serial line `din` at mid-bit and reassembles LSB-first bytes.
- Presents each good byte with a one-cycle valid pulse; flags frames whose stop bit is low.
- Sits between the board RX pin and the command/echo logic.
- Timing matches the transmitter: 100 MHz clk, 115200 baud, 868 clk per bit.

Parameters:
FULL_T, 867, clk cycles per bit minus 1 (bit period = FULL_T+1).
HALF_T, 433, cycle count from start-bit falling edge to start-bit mid-sample.

Ports:
clk  input  1  system clock, 100 MHz.
rst  input  1  reset, synchronous, active-high.
din  input  1  asynchronous serial line, idle high.
din_vld  output  1  one-cycle pulse: din_data holds a newly received good byte.
din_data  output  8  last good byte received, bit0 first on the wire.
frame_err  output  1  one-cycle pulse: stop bit sampled low.

Behaviour:
- Reset values: din_vld=0, frame_err=0, din_data=8'h00, state=IDLE, counters=0, synchroniser flops=1.
- Reset applies mid-frame: the partial frame is discarded and no pulse is produced.
- din passes through a 2-flop synchroniser (din_s). din_s_d is din_s delayed one cycle. Falling edge = din_s_d=1 && din_s=0.
- Counters:
  - div_cnt is 10 bits, range 0..FULL_T, wraps to 0.
  - bit_cnt is 3 bits, range 0..7.
  - shift register is 8 bits.
- FSM states: IDLE, START, DATA, STOP.
- IDLE: div_cnt=0. On a falling edge, go to START.
- START: div_cnt counts up.
  - At div_cnt==HALF_T, sample din_s.
  - din_s=0: go to DATA, div_cnt←0, bit_cnt←0.
  - din_s=1 (glitch): go to IDLE, no outputs.
- DATA: div_cnt counts 0..FULL_T.
  - At div_cnt==FULL_T (mid-bit), shift[bit_cnt]←din_s.
  - If bit_cnt==7, go to STOP; otherwise bit_cnt+1.
  - div_cnt wraps to 0.
- STOP: at div_cnt==FULL_T, sample din_s.
  - din_s=1: din_data←shift, din_vld=1 for exactly one cycle, go to IDLE.
  - din_s=0: frame_err=1 for one cycle, din_data unchanged, go to IDLE.
- After frame_err with the line held low (break), no new frame starts until the line returns high and falls again; the edge detector guarantees this.
- Back-to-back frames: returning to IDLE at mid-stop-bit leaves half a bit for edge detection, so a following start bit is never missed.
- Latency: din_vld/frame_err rise 2 + 1 + HALF_T + 1 + 9*(FULL_T+1) cycles after the din falling edge, i.e. 8249 cycles ≈ 9.5 bit periods. The bench accepts ±3 cycles.
- din_data and din_vld change on the same clock edge.
- din_vld and frame_err are never both asserted.
- Baud tolerance: frames with a sender bit period within ±2% of FULL_T+1 must be received correctly.
- All outputs are registered. No combinational path from din to any output.

Test Plan:
1. Single byte 0x55 at 868 clk/bit, stop high -> one din_vld pulse ~8249 cycles after the start edge; din_data=8'h55; frame_err stays 0.
2. Back-to-back 0xA3, 0x00, 0xFF, each with exactly one stop bit and no idle gap -> three din_vld pulses spaced 8680 cycles apart; din_data=0xA3, 0x00, 0xFF in order.
3. Glitch: din low for 200 cycles, then high -> no din_vld, no frame_err, FSM back in IDLE. A following frame 0x3C is then received correctly.
4. Framing error: 0x3C sent after a good 0x12, with the stop bit driven 0 and the line then held low 5000 cycles before going high -> one frame_err pulse; din_data stays 0x12; a subsequent 0x7E is received correctly.
5. Reset mid-frame: assert rst for 1 cycle during data bit 4 of 0xC6 -> all outputs at reset values; no pulse for that frame; the next frame 0x81 yields din_data=0x81.
6. Loopback: transmitter output wired to din, bytes 0x00..0xFF sent sequentially -> 256 din_vld pulses, each din_data equal to the sent byte, zero frame_err.
